mem_arbiter_rv32: RTL and testbench

Shares the single main-memory port between the instruction cache (refill, read-only) and the data cache (refill or writeback).
- Arbitrates line-sized burst transactions with round-robin priority.
- Sequences each burst beat-by-beat over a req/ack memory handshake.
- Returns per-beat acknowledge and read data to the owning cache.
- Sits between the I/D cache controllers and the external memory interface.

---
 rtl/mem_arbiter_rv32.sv | 137 +++++++++++++
 tb/tb_mem_arbiter_rv32.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rv32.sv
// Round-robin arbiter that shares one main-memory port between I-cache refills
// and D-cache refills/writebacks, and sequences each line burst over the req/ack handshake.
module mem_arbiter_rv32 #(
    parameter int BURST_LEN = 4,
    parameter int BW        = 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iREQ_I,
    input  logic [31:0]   iADDR_I,
    input  logic          iREQ_D,
    input  logic          iWE_D,
    input  logic [31:0]   iADDR_D,
    input  logic [31:0]   iWDATA_D,
    output logic          oGNT_I,
    output logic          oGNT_D,
    output logic [BW-1:0] oBEAT,
    output logic          oACK_I,
    output logic          oACK_D,
    output logic [31:0]   oRDATA,
    output logic          oDONE_I,
    output logic          oDONE_D,
    output logic          oMEM_REQ,
    output logic          oMEM_WE,
    output logic [31:0]   oMEM_ADDR,
    output logic [31:0]   oMEM_WDATA,
    input  logic          iMEM_ACK,
    input  logic [31:0]   iMEM_RDATA
);

    // state | meaning
    // IDLE  | sample requests, pick winner, latch line address
    // BURST | present beats to memory until the last one is acked
    // DONE  | one-cycle done pulse, update round-robin pointer
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [31:0]   LINE_MASK = ~((32'(BURST_LEN) << 2) - 32'd1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [1:0]    state_q, state_d;
    logic          own_d_q, own_d_d;    // 1: D cache owns the current burst
    logic          we_q, we_d;
    logic [31:0]   base_q, base_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          last_d_q, last_d_d;  // 1: D was served last
    logic          ack_i_q, ack_i_d;
    logic          ack_d_q, ack_d_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          pick_dcache;

    always_comb begin
        state_d     = state_q;
        own_d_d     = own_d_q;
        we_d        = we_q;
        base_d      = base_q;
        beat_d      = beat_q;
        last_d_d    = last_d_q;
        ack_i_d     = 1'b0;
        ack_d_d     = 1'b0;
        rdata_d     = rdata_q;
        pick_dcache = iREQ_D && (!iREQ_I || !last_d_q);
        case (state_q)
            S_IDLE: begin
                if (iREQ_I || iREQ_D) begin
                    own_d_d = pick_dcache;
                    we_d    = pick_dcache && iWE_D;
                    base_d  = (pick_dcache ? iADDR_D : iADDR_I) & LINE_MASK;
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (iMEM_ACK) begin
                    beat_d  = beat_q + 1'b1;
                    ack_i_d = !own_d_q;
                    ack_d_d = own_d_q;
                    if (!we_q) begin
                        rdata_d = iMEM_RDATA;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                last_d_d = own_d_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            own_d_q  <= 1'b0;
            we_q     <= 1'b0;
            base_q   <= '0;
            beat_q   <= '0;
            last_d_q <= 1'b1;
            ack_i_q  <= 1'b0;
            ack_d_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            we_q     <= we_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            last_d_q <= last_d_d;
            ack_i_q  <= ack_i_d;
            ack_d_q  <= ack_d_d;
            rdata_q  <= rdata_d;
        end
    end

    logic in_burst, in_done;
    assign in_burst = (state_q == S_BURST);
    assign in_done  = (state_q == S_DONE);

    assign oGNT_I     = in_burst && !own_d_q;
    assign oGNT_D     = in_burst && own_d_q;
    assign oDONE_I    = in_done && !own_d_q;
    assign oDONE_D    = in_done && own_d_q;
    assign oBEAT      = beat_q;
    assign oACK_I     = ack_i_q;
    assign oACK_D     = ack_d_q;
    assign oRDATA     = rdata_q;
    assign oMEM_REQ   = in_burst;
    assign oMEM_WE    = in_burst && we_q;
    // Base is line aligned, so OR-ing in the word offset is the same as adding it.
    assign oMEM_ADDR  = in_burst ? (base_q | {{(30-BW){1'b0}}, beat_q, 2'b00}) : 32'd0;
    assign oMEM_WDATA = (in_burst && own_d_q && we_q) ? iWDATA_D : 32'd0;

endmodule

// File: tb/tb_mem_arbiter_rv32.sv
// Self-checking bench for mem_arbiter_rv32: directed scenarios plus random rounds,
// checked against a transaction-level model of arbitration, addressing and data return.
module tb_mem_arbiter_rv32;

    localparam int BL = 4;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iREQ_I, iREQ_D, iWE_D;
    logic [31:0] iADDR_I, iADDR_D, iWDATA_D;
    logic        oGNT_I, oGNT_D;
    logic [1:0]  oBEAT;
    logic        oACK_I, oACK_D;
    logic [31:0] oRDATA;
    logic        oDONE_I, oDONE_D;
    logic        oMEM_REQ, oMEM_WE;
    logic [31:0] oMEM_ADDR, oMEM_WDATA;
    logic        iMEM_ACK;
    logic [31:0] iMEM_RDATA;

    logic [31:0] wline [BL];
    assign iWDATA_D = wline[oBEAT];

    mem_arbiter_rv32 #(.BURST_LEN(BL), .BW(2)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iREQ_I(iREQ_I), .iADDR_I(iADDR_I),
        .iREQ_D(iREQ_D), .iWE_D(iWE_D), .iADDR_D(iADDR_D), .iWDATA_D(iWDATA_D),
        .oGNT_I(oGNT_I), .oGNT_D(oGNT_D), .oBEAT(oBEAT),
        .oACK_I(oACK_I), .oACK_D(oACK_D), .oRDATA(oRDATA),
        .oDONE_I(oDONE_I), .oDONE_D(oDONE_D),
        .oMEM_REQ(oMEM_REQ), .oMEM_WE(oMEM_WE), .oMEM_ADDR(oMEM_ADDR),
        .oMEM_WDATA(oMEM_WDATA), .iMEM_ACK(iMEM_ACK), .iMEM_RDATA(iMEM_RDATA)
    );

    always #5 iCLK = ~iCLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          last_d;     // model: D was served last
    logic [31:0] exp_rdata;  // model: value the shared read-data output should hold

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt_i"}, oGNT_I, 0);
        chk({tag, ".gnt_d"}, oGNT_D, 0);
        chk({tag, ".mem_req"}, oMEM_REQ, 0);
        chk({tag, ".mem_we"}, oMEM_WE, 0);
        chk({tag, ".mem_addr"}, oMEM_ADDR, 0);
        chk({tag, ".mem_wdata"}, oMEM_WDATA, 0);
        chk({tag, ".ack_i"}, oACK_I, 0);
        chk({tag, ".ack_d"}, oACK_D, 0);
        chk({tag, ".done_i"}, oDONE_I, 0);
        chk({tag, ".done_d"}, oDONE_D, 0);
        chk({tag, ".beat"}, oBEAT, 0);
        chk({tag, ".rdata"}, oRDATA, exp_rdata);
    endtask

    task automatic chk_beat(input bit is_d, input bit we, input logic [31:0] base,
                            input int k, input bit pend);
        chk("beat.gnt_i", oGNT_I, !is_d);
        chk("beat.gnt_d", oGNT_D, is_d);
        chk("beat.mem_req", oMEM_REQ, 1);
        chk("beat.mem_we", oMEM_WE, we);
        chk("beat.mem_addr", oMEM_ADDR, base + 32'(4 * k));
        chk("beat.index", oBEAT, k);
        chk("beat.mem_wdata", oMEM_WDATA, we ? wline[k] : 32'd0);
        chk("beat.ack_i", oACK_I, pend && !is_d);
        chk("beat.ack_d", oACK_D, pend && is_d);
        chk("beat.rdata", oRDATA, exp_rdata);
        chk("beat.done_i", oDONE_I, 0);
        chk("beat.done_d", oDONE_D, 0);
    endtask

    // Entered at the first BURST cycle; returns at the DONE cycle.
    task automatic do_burst(input bit is_d, input bit we, input logic [31:0] base,
                            input int waits, input int drop_beat);
        bit          pend;
        int          w;
        logic [31:0] rd;
        pend = 0;
        for (int k = 0; k < BL; k++) begin
            w = (waits < 0) ? int'($urandom_range(2)) : waits;
            for (int j = 0; j < w; j++) begin
                chk_beat(is_d, we, base, k, pend);
                pend       = 0;
                iMEM_ACK   = 1'b0;
                iMEM_RDATA = $urandom;
                tick();
            end
            chk_beat(is_d, we, base, k, pend);
            rd         = $urandom;
            iMEM_ACK   = 1'b1;
            iMEM_RDATA = rd;
            if (!we) exp_rdata = rd;
            pend = 1;
            if (k == drop_beat) begin
                iREQ_I = 1'b0;
                iREQ_D = 1'b0;
            end
            tick();
        end
        iMEM_ACK = 1'b0;
        chk("done.done_i", oDONE_I, !is_d);
        chk("done.done_d", oDONE_D, is_d);
        chk("done.gnt_i", oGNT_I, 0);
        chk("done.gnt_d", oGNT_D, 0);
        chk("done.mem_req", oMEM_REQ, 0);
        chk("done.ack_i", oACK_I, !is_d);
        chk("done.ack_d", oACK_D, is_d);
        chk("done.rdata", oRDATA, exp_rdata);
        chk("done.beat", oBEAT, 0);
        last_d = is_d;
    endtask

    // Entered and left at a negedge in IDLE.
    task automatic arb_round(input bit r_i, input bit r_d, input bit we_d,
                             input logic [31:0] a_i, input logic [31:0] a_d,
                             input int waits, input int drop_beat, input bit keep);
        bit          is_d;
        bit          we;
        logic [31:0] base;
        chk_idle("idle");
        for (int k = 0; k < BL; k++) wline[k] = $urandom;
        iREQ_I  = r_i;
        iREQ_D  = r_d;
        iWE_D   = we_d;
        iADDR_I = a_i;
        iADDR_D = a_d;
        is_d    = r_d && (!r_i || !last_d);
        we      = is_d && we_d;
        base    = (is_d ? a_d : a_i) & ~32'(4 * BL - 1);
        tick();
        do_burst(is_d, we, base, waits, drop_beat);
        if (!keep) begin
            iREQ_I = 1'b0;
            iREQ_D = 1'b0;
        end
        tick();
    endtask

    initial begin
        logic [31:0] a_rst, base_rst, rd;
        int          r;
        bit          pend;

        iRST = 1'b1; iREQ_I = 0; iREQ_D = 0; iWE_D = 0;
        iADDR_I = 0; iADDR_D = 0; iMEM_ACK = 0; iMEM_RDATA = 0;
        for (int k = 0; k < BL; k++) wline[k] = 0;
        exp_rdata = 0;
        last_d    = 1;
        repeat (3) tick();
        chk_idle("reset");
        iRST = 1'b0;
        tick();
        chk_idle("post_reset");

        // I refill, one wait state per beat
        arb_round(1, 0, 0, 32'h0000_1234, 32'h0, 1, -1, 0);
        // D writeback, back-to-back acks
        arb_round(0, 1, 1, 32'h0, 32'h0000_2000, 0, -1, 0);

        // stray acks while idle
        iMEM_ACK = 1'b1;
        repeat (3) begin
            iMEM_RDATA = $urandom;
            tick();
            chk_idle("stray_ack");
        end
        iMEM_ACK = 1'b0;

        // both requesting and held: expect strict alternation
        for (int n = 0; n < 4; n++)
            arb_round(1, 1, $urandom_range(1), $urandom, $urandom, -1, -1, n < 3);

        // D refill with request dropped after beat 1
        arb_round(0, 1, 0, 32'h0, $urandom, -1, 1, 0);

        // reset during beat 2 of an I burst
        a_rst    = $urandom;
        base_rst = a_rst & ~32'(4 * BL - 1);
        chk_idle("pre_rst_mid");
        iREQ_I  = 1'b1;
        iADDR_I = a_rst;
        tick();
        iREQ_I = 1'b0;
        pend   = 0;
        for (int k = 0; k < 2; k++) begin
            chk_beat(0, 0, base_rst, k, pend);
            rd         = $urandom;
            iMEM_ACK   = 1'b1;
            iMEM_RDATA = rd;
            exp_rdata  = rd;
            pend       = 1;
            tick();
        end
        chk_beat(0, 0, base_rst, 2, pend);
        iMEM_ACK = 1'b0;
        iRST     = 1'b1;
        tick();
        exp_rdata = 0;
        last_d    = 1;
        chk_idle("rst_mid");
        iRST = 1'b0;
        tick();
        chk_idle("rst_mid_no_done");
        arb_round(0, 1, 0, 32'h0, $urandom, -1, -1, 0);

        // random rounds
        for (int n = 0; n < 16; n++) begin
            r = int'($urandom_range(1, 3));
            arb_round(r[0], r[1], $urandom_range(1), $urandom, $urandom, -1,
                      int'($urandom_range(4)) - 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
